// File: rtl/lsq_cdb_arbiter_pkg.sv
// Shared superscalar definitions: common data bus channel tags.
// Every CDB producer takes its fixed tag from here so the encodings stay consistent.
package lsq_cdb_arbiter_pkg;

    typedef enum logic [1:0] {
        CDB_TAG_ALU0 = 2'b00,
        CDB_TAG_ALU1 = 2'b01,
        CDB_TAG_ALU2 = 2'b10,
        CDB_TAG_LSQ  = 2'b11
    } cdb_tag_t;

endpackage

// File: rtl/lsq_cdb_arbiter_fifo.sv
// Result buffer with two ordered write ports, one read port and a flush.
// Port 1 always lands one slot after port 0 when both write in the same cycle.
module cdb_result_fifo_2w1r #(
    parameter  int WIDTH = 38,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr0_en,
    input  logic [WIDTH-1:0] wr0_data,
    input  logic             wr1_en,
    input  logic [WIDTH-1:0] wr1_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr1_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    assign pop     = rd_en && (count_q != '0);
    assign wr1_ptr = wr_ptr_q + PTR_W'(wr0_en);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // NOTE: every signal gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr0_en) mem_d[wr_ptr_q] = wr0_data;
            if (wr1_en) mem_d[wr1_ptr]  = wr1_data;
            // Pointers wrap by truncation because DEPTH is a power of two.
            wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop);
        end
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which slots hold live data.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lsq_cdb_arbiter.sv
// Merges forwarded and memory load results into the LSQ common data bus channel.
// Readiness is judged from registered occupancy, so a same-cycle pop never frees space.
module lsq_cdb_arbiter
    import lsq_cdb_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int PHYS_REG_ADDR_WIDTH = 6,
    parameter int DEPTH               = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           fwd_valid,
    input  logic [DATA_WIDTH-1:0]          fwd_data,
    input  logic [PHYS_REG_ADDR_WIDTH-1:0] fwd_dest,
    output logic                           fwd_ready,
    input  logic                           mem_valid,
    input  logic [DATA_WIDTH-1:0]          mem_data,
    input  logic [PHYS_REG_ADDR_WIDTH-1:0] mem_dest,
    output logic                           mem_ready,
    output logic                           cdb_valid_3,
    output logic [1:0]                     cdb_tag_3,
    output logic [DATA_WIDTH-1:0]          cdb_data_3,
    output logic [PHYS_REG_ADDR_WIDTH-1:0] cdb_dest_reg_3,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_WIDTH + PHYS_REG_ADDR_WIDTH;

    logic [OCC_W-1:0]   free;
    logic               fwd_enq, mem_enq;
    logic               wr0_en, wr1_en;
    logic [ENTRY_W-1:0] wr0_data, wr1_data, head_entry;

    assign free      = OCC_W'(DEPTH) - occupancy;
    assign fwd_ready = (free >= OCC_W'(1));
    // Memory yields the last free slot to a forwarding push in the same cycle.
    assign mem_ready = (free >= OCC_W'(2)) || ((free >= OCC_W'(1)) && !fwd_valid);

    // Dest-0 results complete the handshake but have no architectural target to wake.
    assign fwd_enq = fwd_valid && fwd_ready && !flush && (fwd_dest != '0);
    assign mem_enq = mem_valid && mem_ready && !flush && (mem_dest != '0);

    assign wr0_en   = fwd_enq || mem_enq;
    assign wr0_data = fwd_enq ? {fwd_data, fwd_dest} : {mem_data, mem_dest};
    assign wr1_en   = fwd_enq && mem_enq;
    assign wr1_data = {mem_data, mem_dest};

    cdb_result_fifo_2w1r #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (1'b1),
        .rd_data  (head_entry),
        .count    (occupancy)
    );

    assign cdb_valid_3                  = (occupancy != '0);
    assign {cdb_data_3, cdb_dest_reg_3} = cdb_valid_3 ? head_entry : '0;
    assign cdb_tag_3                    = CDB_TAG_LSQ;

endmodule

// File: tb/tb_lsq_cdb_arbiter.sv
// Directed bench for lsq_cdb_arbiter: a scoreboard queue holds expected broadcasts,
// and a negedge monitor pops and compares whenever the CDB channel is valid.
module tb_lsq_cdb_arbiter;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  dest;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        fwd_valid = 1'b0, mem_valid = 1'b0;
    logic [31:0] fwd_data = '0, mem_data = '0;
    logic [5:0]  fwd_dest = '0, mem_dest = '0;
    logic        fwd_ready, mem_ready, cdb_valid_3;
    logic [1:0]  cdb_tag_3;
    logic [31:0] cdb_data_3;
    logic [5:0]  cdb_dest_reg_3;
    logic [2:0]  occupancy;

    // Second instance with DEPTH=2: continuous popping never lets DEPTH=4 fill completely.
    logic        fwd_valid_s = 1'b0, mem_valid_s = 1'b0;
    logic [31:0] fwd_data_s = '0, mem_data_s = '0;
    logic [5:0]  fwd_dest_s = '0, mem_dest_s = '0;
    logic        fwd_ready_s, mem_ready_s, cdb_valid_s;
    logic [1:0]  cdb_tag_s;
    logic [31:0] cdb_data_s;
    logic [5:0]  cdb_dest_s;
    logic [1:0]  occupancy_s;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    lsq_cdb_arbiter #(.DATA_WIDTH(32), .PHYS_REG_ADDR_WIDTH(6), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_dest(fwd_dest), .fwd_ready(fwd_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_dest(mem_dest), .mem_ready(mem_ready),
        .cdb_valid_3(cdb_valid_3), .cdb_tag_3(cdb_tag_3), .cdb_data_3(cdb_data_3),
        .cdb_dest_reg_3(cdb_dest_reg_3), .occupancy(occupancy)
    );

    lsq_cdb_arbiter #(.DATA_WIDTH(32), .PHYS_REG_ADDR_WIDTH(6), .DEPTH(2)) dut_small (
        .clk(clk), .reset(reset), .flush(1'b0),
        .fwd_valid(fwd_valid_s), .fwd_data(fwd_data_s), .fwd_dest(fwd_dest_s), .fwd_ready(fwd_ready_s),
        .mem_valid(mem_valid_s), .mem_data(mem_data_s), .mem_dest(mem_dest_s), .mem_ready(mem_ready_s),
        .cdb_valid_3(cdb_valid_s), .cdb_tag_3(cdb_tag_s), .cdb_data_3(cdb_data_s),
        .cdb_dest_reg_3(cdb_dest_s), .occupancy(occupancy_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] fd, input logic [5:0] fdst,
                         input logic mv, input logic [31:0] md, input logic [5:0] mdst);
        fwd_valid = fv; fwd_data = fd; fwd_dest = fdst;
        mem_valid = mv; mem_data = md; mem_dest = mdst;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic expect_bcast(input logic [31:0] d, input logic [5:0] dst);
        exp_t e;
        e.data = d;
        e.dest = dst;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every valid broadcast against the scoreboard head.
    always @(negedge clk) begin
        if (cdb_valid_3) begin
            check("bcast_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("bcast_data", 64'(cdb_data_3), 64'(mon_e.data));
                check("bcast_dest", 64'(cdb_dest_reg_3), 64'(mon_e.dest));
            end
            check("bcast_tag", 64'(cdb_tag_3), 64'(2'b11));
        end else begin
            check("idle_zero", 64'({cdb_data_3, cdb_dest_reg_3}), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, observed while reset is held.
        #2;
        check("rst_valid", 64'(cdb_valid_3), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_fwd_ready", 64'(fwd_ready), 64'd1);
        check("rst_mem_ready", 64'(mem_ready), 64'd1);
        step();
        step();
        reset = 1'b0;

        // Single memory push into an empty buffer: broadcast one cycle later, then idle.
        drive(1'b0, '0, '0, 1'b1, 32'hDEADBEEF, 6'd5);
        #1 check("single_mem_ready", 64'(mem_ready), 64'd1);
        expect_bcast(32'hDEADBEEF, 6'd5);
        step();
        idle();
        check("single_occ1", 64'(occupancy), 64'd1);
        check("single_valid1", 64'(cdb_valid_3), 64'd1);
        step();
        check("single_valid0", 64'(cdb_valid_3), 64'd0);
        check("single_occ0", 64'(occupancy), 64'd0);

        // Simultaneous pushes: forwarded result broadcasts first.
        drive(1'b1, 32'h11, 6'd3, 1'b1, 32'h22, 6'd4);
        #1 check("dual_fwd_ready", 64'(fwd_ready), 64'd1);
        check("dual_mem_ready", 64'(mem_ready), 64'd1);
        expect_bcast(32'h11, 6'd3);
        expect_bcast(32'h22, 6'd4);
        step();
        idle();
        check("dual_occ2", 64'(occupancy), 64'd2);
        step();
        check("dual_occ1", 64'(occupancy), 64'd1);
        step();
        check("dual_occ0", 64'(occupancy), 64'd0);

        // Ready arbitration at occupancy 3.
        drive(1'b1, 32'h101, 6'd10, 1'b1, 32'h102, 6'd11);
        expect_bcast(32'h101, 6'd10);
        expect_bcast(32'h102, 6'd11);
        step();
        drive(1'b1, 32'h103, 6'd12, 1'b1, 32'h104, 6'd13);
        #1 check("occ2_mem_ready", 64'(mem_ready), 64'd1);
        expect_bcast(32'h103, 6'd12);
        expect_bcast(32'h104, 6'd13);
        step();
        check("fill_occ3", 64'(occupancy), 64'd3);
        drive(1'b1, 32'h105, 6'd14, 1'b1, 32'h106, 6'd15);
        #1 check("occ3_fwd_ready", 64'(fwd_ready), 64'd1);
        check("occ3_mem_ready_fwd", 64'(mem_ready), 64'd0);
        expect_bcast(32'h105, 6'd14);
        step();
        check("occ3_hold", 64'(occupancy), 64'd3);
        drive(1'b0, '0, '0, 1'b1, 32'h107, 6'd16);
        #1 check("occ3_mem_ready_alone", 64'(mem_ready), 64'd1);
        expect_bcast(32'h107, 6'd16);
        step();
        idle();
        check("occ3_hold2", 64'(occupancy), 64'd3);
        repeat (3) step();
        check("drain_occ0", 64'(occupancy), 64'd0);

        // Flush at occupancy 3 together with a memory push.
        drive(1'b1, 32'h201, 6'd20, 1'b1, 32'h202, 6'd21);
        expect_bcast(32'h201, 6'd20);
        expect_bcast(32'h202, 6'd21);
        step();
        drive(1'b1, 32'h203, 6'd22, 1'b1, 32'h204, 6'd23);
        expect_bcast(32'h203, 6'd22);
        expect_bcast(32'h204, 6'd23);
        step();
        check("flush_pre_occ3", 64'(occupancy), 64'd3);
        drive(1'b0, '0, '0, 1'b1, 32'h2FF, 6'd24);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        exp_q.delete();
        check("flush_occ0", 64'(occupancy), 64'd0);
        check("flush_valid0", 64'(cdb_valid_3), 64'd0);
        repeat (2) step();

        // Dest-0 pushes handshake but are never enqueued.
        drive(1'b0, '0, '0, 1'b1, 32'h55, 6'd0);
        #1 check("dest0_mem_ready", 64'(mem_ready), 64'd1);
        step();
        idle();
        check("dest0_occ", 64'(occupancy), 64'd0);
        drive(1'b1, 32'h66, 6'd0, 1'b1, 32'h77, 6'd7);
        expect_bcast(32'h77, 6'd7);
        step();
        idle();
        check("dest0_mixed_occ", 64'(occupancy), 64'd1);
        step();
        check("dest0_mixed_occ0", 64'(occupancy), 64'd0);

        // Asynchronous reset in the middle of a stream.
        drive(1'b1, 32'h301, 6'd30, 1'b1, 32'h302, 6'd31);
        expect_bcast(32'h301, 6'd30);
        expect_bcast(32'h302, 6'd31);
        step();
        drive(1'b1, 32'h303, 6'd32, 1'b1, 32'h304, 6'd33);
        expect_bcast(32'h303, 6'd32);
        expect_bcast(32'h304, 6'd33);
        step();
        idle();
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        check("async_rst_valid", 64'(cdb_valid_3), 64'd0);
        check("async_rst_data", 64'({cdb_data_3, cdb_dest_reg_3}), 64'd0);
        check("async_rst_occ", 64'(occupancy), 64'd0);
        check("async_rst_fwd_ready", 64'(fwd_ready), 64'd1);
        check("async_rst_mem_ready", 64'(mem_ready), 64'd1);
        step();
        step();
        reset = 1'b0;
        check("post_rst_fwd_ready", 64'(fwd_ready), 64'd1);
        check("post_rst_mem_ready", 64'(mem_ready), 64'd1);
        repeat (3) step();
        check("post_rst_occ", 64'(occupancy), 64'd0);
        drive(1'b0, '0, '0, 1'b1, 32'h400, 6'd40);
        expect_bcast(32'h400, 6'd40);
        step();
        idle();
        repeat (2) step();

        // Completely full buffer (DEPTH=2): both readys drop and nothing is overwritten.
        fwd_valid_s = 1'b1; fwd_data_s = 32'hA1; fwd_dest_s = 6'd1;
        mem_valid_s = 1'b1; mem_data_s = 32'hA2; mem_dest_s = 6'd2;
        #1 check("small_fwd_ready0", 64'(fwd_ready_s), 64'd1);
        check("small_mem_ready0", 64'(mem_ready_s), 64'd1);
        step();
        fwd_data_s = 32'hB1; fwd_dest_s = 6'd5;
        mem_data_s = 32'hB2; mem_dest_s = 6'd6;
        #1 check("small_full_occ", 64'(occupancy_s), 64'd2);
        check("small_full_fwd_ready", 64'(fwd_ready_s), 64'd0);
        check("small_full_mem_ready", 64'(mem_ready_s), 64'd0);
        check("small_head0", 64'({cdb_data_s, cdb_dest_s}), 64'({32'hA1, 6'd1}));
        step();
        fwd_valid_s = 1'b0;
        mem_valid_s = 1'b0;
        check("small_occ1", 64'(occupancy_s), 64'd1);
        check("small_head1", 64'({cdb_data_s, cdb_dest_s}), 64'({32'hA2, 6'd2}));
        step();
        check("small_valid0", 64'(cdb_valid_s), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsq_cdb_arbiter.md
LSQ_CDB_ARBITER -- requirements
Module: lsq_cdb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, result data width.
REQ-002 SHALL have parameter PHYS_REG_ADDR_WIDTH, default 6, physical register address width.
REQ-003 SHALL have parameter DEPTH, default 4, result buffer entries; power of two, at least 2.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, pipeline flush (mispredict or exception).
REQ-008 SHALL have port fwd_valid, input, 1, store-to-load forwarded result valid.
REQ-009 SHALL have port fwd_data, input, DATA_WIDTH, forwarded load data.
REQ-010 SHALL have port fwd_dest, input, PHYS_REG_ADDR_WIDTH, forwarded load destination register.
REQ-011 SHALL have port fwd_ready, output, 1, forwarding source may push this cycle.
REQ-012 SHALL have port mem_valid, input, 1, memory load response valid.
REQ-013 SHALL have port mem_data, input, DATA_WIDTH, load data returned from memory.
REQ-014 SHALL have port mem_dest, input, PHYS_REG_ADDR_WIDTH, memory load destination register.
REQ-015 SHALL have port mem_ready, output, 1, memory response may push this cycle.
REQ-016 SHALL have port cdb_valid_3, output, 1, LSQ CDB channel valid.
REQ-017 SHALL have port cdb_tag_3, output, 2, channel tag.
REQ-018 SHALL have port cdb_data_3, output, DATA_WIDTH, broadcast data.
REQ-019 SHALL have port cdb_dest_reg_3, output, PHYS_REG_ADDR_WIDTH, broadcast destination register.
REQ-020 SHALL have port occupancy, output, $clog2(DEPTH+1), registered entry count.

Function
REQ-021 SHALL accept a push on a source when its valid and ready are both high in the same cycle.
REQ-022 SHALL compute free = DEPTH - occupancy from registered state only; a pop in the same cycle does not free space.
REQ-023 SHALL drive fwd_ready = (free >= 1).
REQ-024 SHALL drive mem_ready = (free >= 2) or (free >= 1 and not fwd_valid).
REQ-025 SHALL, when both sources push in one cycle, enqueue the forwarded result before the memory result.
REQ-026 SHALL accept pushes with dest 0 (handshake completes) and SHALL NOT enqueue them.
REQ-027 SHALL pop the head entry every cycle the buffer is non-empty; the CDB applies no back-pressure.
REQ-028 SHALL drive cdb_valid_3, cdb_data_3 and cdb_dest_reg_3 from registered head state.
REQ-029 SHALL give latency exactly 1 cycle from push accept to CDB broadcast when the buffer is empty.
REQ-030 SHALL drive cdb_tag_3 constant 2'b11 at all times.
REQ-031 SHALL drive cdb_data_3 and cdb_dest_reg_3 to 0 when cdb_valid_3 is 0.
REQ-032 SHALL wrap read and write pointers modulo DEPTH.
REQ-033 SHALL update occupancy as occupancy + pushes_enqueued - pop; the result SHALL never exceed DEPTH or go below 0.
REQ-034 SHALL, on flush, clear all entries and set occupancy to 0 on the next edge.
REQ-035 SHALL discard pushes that arrive in the same cycle as flush.
REQ-036 SHALL drive cdb_valid_3 = 0 in the cycle following flush.
REQ-037 SHALL broadcast entries strictly in enqueue order.

Reset
REQ-038 SHALL, on reset assertion, immediately clear pointers and occupancy and set cdb_valid_3, cdb_data_3 and cdb_dest_reg_3 to 0.
REQ-039 SHALL drive fwd_ready and mem_ready to 1 during and after reset.
REQ-040 SHALL lose any in-flight entries when reset asserts mid-operation; no broadcast follows release until a new push.

Structure
REQ-041 SHALL take CDB tag constants (CDB_TAG_ALU0=2'b00, ALU1=2'b01, ALU2=2'b10, LSQ=2'b11) from a shared superscalar package.
REQ-042 SHALL implement storage as one sub-module, cdb_result_fifo_2w1r (two write ports, one read port, flush).

Verification
REQ-043 Empty buffer, mem push of data 0xDEADBEEF to dest 5 -> next cycle cdb_valid_3=1, data 0xDEADBEEF, dest 5, tag 2'b11; the cycle after, cdb_valid_3=0.
REQ-044 Same-cycle fwd (0x11 to dest 3) and mem (0x22 to dest 4) pushes -> broadcast of dest 3 then dest 4 on consecutive cycles.
REQ-045 Occupancy 3 with fwd_valid=1 -> mem_ready=0 and fwd_ready=1; at occupancy 4 both readys=0 and no entry is overwritten.
REQ-046 Occupancy 3 with flush asserted together with a mem push -> next cycle occupancy=0, cdb_valid_3=0, and the pushed result is never broadcast.
REQ-047 Push with dest 0 -> handshake completes, occupancy unchanged, no broadcast.
REQ-048 Reset asserted asynchronously mid-stream -> outputs go to 0 immediately; after release, readys=1 and no stale broadcast appears.
